// File: rtl/clock_pkg.sv
// ----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the time-of-day counter:
//   BCD_W      : width of one packed-BCD field (two digits)
//   BCD_ZERO   : 8'h00
//   BCD_59     : wrap value for minutes / seconds
//   BCD_23     : wrap value for hours
//   tod_t      : packed {hh, mm, ss} time-of-day value
//   bcd_valid  : both digits decimal and value not above a BCD limit
//   bcd_inc    : two-digit BCD increment (no wrap handling)
// ----------------------------------------------------------------------------
package clock_pkg;

    localparam int BCD_W = 8;

    localparam logic [BCD_W-1:0] BCD_ZERO = 8'h00;
    localparam logic [BCD_W-1:0] BCD_59   = 8'h59;
    localparam logic [BCD_W-1:0] BCD_23   = 8'h23;

    typedef struct packed {
        logic [BCD_W-1:0] hh;
        logic [BCD_W-1:0] mm;
        logic [BCD_W-1:0] ss;
    } tod_t;

    // For two legal BCD digits, numeric comparison of the packed byte matches
    // decimal ordering, so the limit check can be a plain unsigned compare.
    function automatic logic bcd_valid(input logic [BCD_W-1:0] v,
                                       input logic [BCD_W-1:0] lim);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= lim);
    endfunction

    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// ----------------------------------------------------------------------------
// bcd_mod_counter
// Two-digit BCD counter that wraps to 00 after reaching a programmable max.
// Ports:
//   CLOCK     in   system clock
//   RESET     in   synchronous active-high reset (value -> 00)
//   inc       in   advance by one this cycle
//   load      in   replace value with load_val (wins over inc)
//   load_val  in   BCD value to load
//   max       in   BCD value after which the counter wraps
//   value     out  current BCD value
//   carry_out out  combinational: inc while value == max (wrap happening)
// ----------------------------------------------------------------------------
module bcd_mod_counter
    import clock_pkg::*;
(
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             inc,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    input  logic [BCD_W-1:0] max,
    output logic [BCD_W-1:0] value,
    output logic             carry_out
);

    assign carry_out = inc & (value == max);

    always_ff @(posedge CLOCK) begin
        if (RESET)
            value <= BCD_ZERO;
        else if (load)
            value <= load_val;
        else if (inc)
            value <= carry_out ? BCD_ZERO : bcd_inc(value);
    end

endmodule

// File: rtl/time_of_day_counter.sv
// ----------------------------------------------------------------------------
// time_of_day_counter
// 24-hour BCD HH:MM:SS wall clock advanced by rising edges of TICK (1 Hz from
// the clock generator). TICK is sampled and edge-detected in the CLOCK domain.
// Ports:
//   CLOCK      in   system clock
//   RESET      in   synchronous active-high reset
//   TICK       in   1 Hz divided clock; each rising edge is one second
//   Enable     in   count enable; ticks seen while low are discarded
//   SET_LOAD   in   one-cycle request to load SET_TIME
//   SET_TIME   in   BCD {HH, MM, SS}
//   SECONDS    out  BCD seconds
//   MINUTES    out  BCD minutes
//   HOURS      out  BCD hours
//   SEC_PULSE  out  one-cycle strobe per accepted tick
//   DAY_ROLL   out  one-cycle strobe on 23:59:59 -> 00:00:00
//   LOAD_ERR   out  one-cycle strobe when a load value is rejected
// Optional (macro TIME_OF_DAY_ALARM_EN):
//   ALARM_SET  in   latch ALARM_TIME into the alarm register and arm it
//   ALARM_TIME in   BCD {HH, MM}
//   ALARM_ACK  in   clears ALARM
//   ALARM      out  sticky alarm flag, set when time reaches HH:MM:00
// ----------------------------------------------------------------------------
module time_of_day_counter
    import clock_pkg::*;
#(
    parameter logic [BCD_W-1:0] HOURS_MAX  = BCD_23,
    parameter logic [BCD_W-1:0] MINSEC_MAX = BCD_59
)(
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             TICK,
    input  logic             Enable,
    input  logic             SET_LOAD,
    input  logic [23:0]      SET_TIME,
    output logic [BCD_W-1:0] SECONDS,
    output logic [BCD_W-1:0] MINUTES,
    output logic [BCD_W-1:0] HOURS,
    output logic             SEC_PULSE,
    output logic             DAY_ROLL,
    output logic             LOAD_ERR
`ifdef TIME_OF_DAY_ALARM_EN
    ,
    input  logic             ALARM_SET,
    input  logic [15:0]      ALARM_TIME,
    input  logic             ALARM_ACK,
    output logic             ALARM
`endif
);

    tod_t set_tod;
    logic tick_d;
    logic tick_rise;
    logic accept;
    logic time_ok;
    logic load_ok;
    logic sec_carry;
    logic min_carry;
    logic hr_carry;
    logic alarm_err;

    assign set_tod   = tod_t'(SET_TIME);
    assign tick_rise = TICK & ~tick_d;
    // A load on the same cycle as a tick swallows that tick.
    assign accept    = tick_rise & Enable & ~SET_LOAD;
    assign time_ok   = bcd_valid(set_tod.hh, HOURS_MAX) &
                       bcd_valid(set_tod.mm, MINSEC_MAX) &
                       bcd_valid(set_tod.ss, MINSEC_MAX);
    assign load_ok   = SET_LOAD & time_ok;

    bcd_mod_counter u_sec (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .inc      (accept),
        .load     (load_ok),
        .load_val (set_tod.ss),
        .max      (MINSEC_MAX),
        .value    (SECONDS),
        .carry_out(sec_carry)
    );

    bcd_mod_counter u_min (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .inc      (sec_carry),
        .load     (load_ok),
        .load_val (set_tod.mm),
        .max      (MINSEC_MAX),
        .value    (MINUTES),
        .carry_out(min_carry)
    );

    bcd_mod_counter u_hr (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .inc      (min_carry),
        .load     (load_ok),
        .load_val (set_tod.hh),
        .max      (HOURS_MAX),
        .value    (HOURS),
        .carry_out(hr_carry)
    );

`ifdef TIME_OF_DAY_ALARM_EN
    logic [15:0]      alarm_reg;
    logic             armed;
    logic             alarm_ok;
    logic             alarm_hit;
    logic [BCD_W-1:0] next_mm;
    logic [BCD_W-1:0] next_hh;

    assign alarm_ok  = bcd_valid(ALARM_TIME[15:8], HOURS_MAX) &
                       bcd_valid(ALARM_TIME[7:0], MINSEC_MAX);
    assign alarm_err = ALARM_SET & ~alarm_ok;

    // Look ahead to the time this tick produces; seconds land on 00 only when
    // they wrap, so a match is only possible on a seconds carry.
    assign next_mm   = min_carry ? BCD_ZERO :
                       (sec_carry ? bcd_inc(MINUTES) : MINUTES);
    assign next_hh   = hr_carry  ? BCD_ZERO :
                       (min_carry ? bcd_inc(HOURS) : HOURS);
    assign alarm_hit = armed & sec_carry & ({next_hh, next_mm} == alarm_reg);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            alarm_reg <= 16'h0000;
            armed     <= 1'b0;
            ALARM     <= 1'b0;
        end else begin
            if (ALARM_SET && alarm_ok) begin
                alarm_reg <= ALARM_TIME;
                armed     <= 1'b1;
            end
            // A fresh match outranks a simultaneous acknowledge.
            if (alarm_hit)
                ALARM <= 1'b1;
            else if (ALARM_ACK)
                ALARM <= 1'b0;
        end
    end
`else
    assign alarm_err = 1'b0;
`endif

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            // Starting high means a TICK already high at release is not a rise.
            tick_d    <= 1'b1;
            SEC_PULSE <= 1'b0;
            DAY_ROLL  <= 1'b0;
            LOAD_ERR  <= 1'b0;
        end else begin
            tick_d    <= TICK;
            SEC_PULSE <= accept;
            DAY_ROLL  <= hr_carry;
            LOAD_ERR  <= (SET_LOAD & ~time_ok) | alarm_err;
        end
    end

endmodule

// File: tb/tb_time_of_day_counter.sv
// ----------------------------------------------------------------------------
// tb_time_of_day_counter
// Directed, table-driven bench for time_of_day_counter. Each table row is the
// input set for one CLOCK cycle and the outputs expected right after that edge.
// Hand-written sequences cover reset behaviour and the optional alarm.
// ----------------------------------------------------------------------------
module tb_time_of_day_counter;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        TICK;
    logic        Enable;
    logic        SET_LOAD;
    logic [23:0] SET_TIME;
    logic [7:0]  SECONDS;
    logic [7:0]  MINUTES;
    logic [7:0]  HOURS;
    logic        SEC_PULSE;
    logic        DAY_ROLL;
    logic        LOAD_ERR;
`ifdef TIME_OF_DAY_ALARM_EN
    logic        ALARM_SET;
    logic [15:0] ALARM_TIME;
    logic        ALARM_ACK;
    logic        ALARM;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLOCK = ~CLOCK;

    time_of_day_counter dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .TICK      (TICK),
        .Enable    (Enable),
        .SET_LOAD  (SET_LOAD),
        .SET_TIME  (SET_TIME),
        .SECONDS   (SECONDS),
        .MINUTES   (MINUTES),
        .HOURS     (HOURS),
        .SEC_PULSE (SEC_PULSE),
        .DAY_ROLL  (DAY_ROLL),
        .LOAD_ERR  (LOAD_ERR)
`ifdef TIME_OF_DAY_ALARM_EN
        ,
        .ALARM_SET (ALARM_SET),
        .ALARM_TIME(ALARM_TIME),
        .ALARM_ACK (ALARM_ACK),
        .ALARM     (ALARM)
`endif
    );

    typedef struct {
        logic        tick;
        logic        en;
        logic        ld;
        logic [23:0] set_t;
        logic [23:0] exp_t;
        logic        exp_sp;
        logic        exp_dr;
        logic        exp_le;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input logic tick, input logic en, input logic ld,
                        input logic [23:0] set_t, input logic [23:0] exp_t,
                        input logic exp_sp, input logic exp_dr, input logic exp_le);
        vec_t v;
        v.tick = tick; v.en = en; v.ld = ld; v.set_t = set_t;
        v.exp_t = exp_t; v.exp_sp = exp_sp; v.exp_dr = exp_dr; v.exp_le = exp_le;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance one CLOCK edge and settle just after it.
    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [23:0] t,
                           input logic sp, input logic dr, input logic le);
        chk({tag, "_time"}, {HOURS, MINUTES, SECONDS}, t);
        chk({tag, "_sp"}, {23'd0, SEC_PULSE}, {23'd0, sp});
        chk({tag, "_dr"}, {23'd0, DAY_ROLL}, {23'd0, dr});
        chk({tag, "_le"}, {23'd0, LOAD_ERR}, {23'd0, le});
    endtask

    initial begin
        RESET = 1'b1; TICK = 1'b1; Enable = 1'b1; SET_LOAD = 1'b0; SET_TIME = '0;
`ifdef TIME_OF_DAY_ALARM_EN
        ALARM_SET = 1'b0; ALARM_TIME = '0; ALARM_ACK = 1'b0;
`endif

        // Reset held with TICK high, then release with TICK still high.
        for (int i = 0; i < 3; i++) step();
        chk_all("reset", 24'h000000, 1'b0, 1'b0, 1'b0);
`ifdef TIME_OF_DAY_ALARM_EN
        chk("reset_alarm", {23'd0, ALARM}, 24'd0);
`endif
        RESET = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_all($sformatf("tickhigh%0d", i), 24'h000000, 1'b0, 1'b0, 1'b0);
        end

        //   tick en ld  set_time     expected     sp dr le
        addv(0, 1, 1, 24'h123456, 24'h123456, 0, 0, 0);
        addv(1, 1, 0, 24'h000000, 24'h123457, 1, 0, 0);
        addv(1, 1, 0, 24'h000000, 24'h123457, 0, 0, 0);
        addv(0, 1, 0, 24'h000000, 24'h123457, 0, 0, 0);
        addv(1, 1, 0, 24'h000000, 24'h123458, 1, 0, 0);
        addv(0, 1, 0, 24'h000000, 24'h123458, 0, 0, 0);
        addv(1, 1, 0, 24'h000000, 24'h123459, 1, 0, 0);
        addv(0, 1, 0, 24'h000000, 24'h123459, 0, 0, 0);
        addv(1, 1, 0, 24'h000000, 24'h123500, 1, 0, 0);
        addv(0, 1, 0, 24'h000000, 24'h123500, 0, 0, 0);
        addv(1, 1, 0, 24'h000000, 24'h123501, 1, 0, 0);
        addv(0, 1, 0, 24'h000000, 24'h123501, 0, 0, 0);
        // Day rollover.
        addv(0, 1, 1, 24'h235958, 24'h235958, 0, 0, 0);
        addv(1, 1, 0, 24'h000000, 24'h235959, 1, 0, 0);
        addv(0, 1, 0, 24'h000000, 24'h235959, 0, 0, 0);
        addv(1, 1, 0, 24'h000000, 24'h000000, 1, 1, 0);
        addv(1, 1, 0, 24'h000000, 24'h000000, 0, 0, 0);
        addv(0, 1, 0, 24'h000000, 24'h000000, 0, 0, 0);
        // Rejected loads.
        addv(0, 1, 1, 24'h240000, 24'h000000, 0, 0, 1);
        addv(0, 1, 0, 24'h000000, 24'h000000, 0, 0, 0);
        addv(0, 1, 1, 24'h125A00, 24'h000000, 0, 0, 1);
        addv(0, 1, 0, 24'h000000, 24'h000000, 0, 0, 0);
        // Load coincident with a tick rise: tick dropped.
        addv(1, 1, 1, 24'h010203, 24'h010203, 0, 0, 0);
        addv(0, 1, 0, 24'h000000, 24'h010203, 0, 0, 0);
        // Enable low across three rises.
        addv(1, 0, 0, 24'h000000, 24'h010203, 0, 0, 0);
        addv(0, 0, 0, 24'h000000, 24'h010203, 0, 0, 0);
        addv(1, 0, 0, 24'h000000, 24'h010203, 0, 0, 0);
        addv(0, 0, 0, 24'h000000, 24'h010203, 0, 0, 0);
        addv(1, 0, 0, 24'h000000, 24'h010203, 0, 0, 0);
        addv(0, 0, 0, 24'h000000, 24'h010203, 0, 0, 0);
        addv(1, 1, 0, 24'h000000, 24'h010204, 1, 0, 0);
        // Rise seen while disabled is lost, not held over to re-enable.
        addv(0, 0, 0, 24'h000000, 24'h010204, 0, 0, 0);
        addv(1, 0, 0, 24'h000000, 24'h010204, 0, 0, 0);
        addv(1, 1, 0, 24'h000000, 24'h010204, 0, 0, 0);
        // Low-digit 9 -> 0 carries.
        addv(0, 1, 1, 24'h095909, 24'h095909, 0, 0, 0);
        addv(1, 1, 0, 24'h000000, 24'h095910, 1, 0, 0);
        addv(0, 1, 0, 24'h000000, 24'h095910, 0, 0, 0);
        addv(0, 1, 1, 24'h095959, 24'h095959, 0, 0, 0);
        addv(1, 1, 0, 24'h000000, 24'h100000, 1, 0, 0);
        addv(0, 1, 0, 24'h000000, 24'h100000, 0, 0, 0);
        addv(0, 1, 1, 24'h12006A, 24'h100000, 0, 0, 1);
        addv(0, 1, 0, 24'h000000, 24'h100000, 0, 0, 0);

        foreach (vecs[i]) begin
            TICK = vecs[i].tick; Enable = vecs[i].en;
            SET_LOAD = vecs[i].ld; SET_TIME = vecs[i].set_t;
            step();
            chk_all($sformatf("row%0d", i), vecs[i].exp_t, vecs[i].exp_sp,
                    vecs[i].exp_dr, vecs[i].exp_le);
        end
        SET_LOAD = 1'b0; Enable = 1'b1;

        // Reset mid-count, and TICK high after reset release must not count.
        TICK = 1'b1; step();
        chk_all("premid", 24'h100001, 1'b1, 1'b0, 1'b0);
        TICK = 1'b0; RESET = 1'b1; step();
        chk_all("midreset", 24'h000000, 1'b0, 1'b0, 1'b0);
        RESET = 1'b0; TICK = 1'b1; step();
        chk_all("postreset", 24'h000000, 1'b0, 1'b0, 1'b0);

`ifdef TIME_OF_DAY_ALARM_EN
        TICK = 1'b0; ALARM_SET = 1'b1; ALARM_TIME = 16'h0630; step();
        ALARM_SET = 1'b0;
        chk("alarm_set_le", {23'd0, LOAD_ERR}, 24'd0);
        SET_LOAD = 1'b1; SET_TIME = 24'h062959; step();
        SET_LOAD = 1'b0;
        chk("alarm_pre", {23'd0, ALARM}, 24'd0);
        TICK = 1'b1; step();
        chk("alarm_time", {HOURS, MINUTES, SECONDS}, 24'h063000);
        chk("alarm_hit", {23'd0, ALARM}, 24'd1);
        for (int i = 0; i < 3; i++) begin
            TICK = 1'b0; step();
            TICK = 1'b1; step();
            chk($sformatf("alarm_hold%0d", i), {23'd0, ALARM}, 24'd1);
        end
        TICK = 1'b0; ALARM_ACK = 1'b1; step();
        ALARM_ACK = 1'b0;
        chk("alarm_ack", {23'd0, ALARM}, 24'd0);
        ALARM_SET = 1'b1; ALARM_TIME = 16'h2400; step();
        ALARM_SET = 1'b0;
        chk("alarm_bad_le", {23'd0, LOAD_ERR}, 24'd1);
        step();
        chk("alarm_bad_le_clr", {23'd0, LOAD_ERR}, 24'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
